// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: shared types and constants for the PLL configuration shifter.
package pll_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD      = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    localparam logic [1:0] STATUS_LOCKED  = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b01;

    localparam int unsigned DEF_CFG_BITS     = 26;
    localparam int unsigned DEF_SCLK_DIV     = 2;
    localparam int unsigned DEF_RST_HOLD     = 4;
    localparam int unsigned DEF_LOCK_TIMEOUT = 1024;

endpackage

// File: rtl/pll_cfg_sync2.sv
// pll_cfg_sync2: two-flop synchronizer for the asynchronous PLL lock flag.
module pll_cfg_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops to settle metastability before use.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_cfg_shifter.sv
// pll_cfg_shifter: holds the PLL in reset, shifts a new configuration word
// into its dynamic-configuration chain over SCLK/SDI, releases reset and
// reports lock or lock timeout.
// Build option PLL_CFG_READBACK_EN: capture the previous chain contents from
// SDO into rsp_rdata; without it rsp_rdata is tied to 0 and SDO is ignored.
module pll_cfg_shifter
    import pll_cfg_pkg::*;
#(
    parameter int unsigned CFG_BITS     = DEF_CFG_BITS,
    parameter int unsigned SCLK_DIV     = DEF_SCLK_DIV,
    parameter int unsigned RST_HOLD     = DEF_RST_HOLD,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CFG_BITS-1:0] req_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_status,
    output logic [CFG_BITS-1:0] rsp_rdata,
    output logic                busy,
    output logic                pll_sclk,
    output logic                pll_sdi,
    input  logic                pll_sdo,
    output logic                pll_resetb,
    input  logic                pll_lock
);

    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int unsigned PH_W   = $clog2(2 * SCLK_DIV);
    localparam int unsigned BIT_W  = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int unsigned TMO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [CFG_BITS-1:0] data_q;
    logic                lock_s, lock_prev_q;
    logic                sclk_d, sdi_d, resetb_d;
    logic [1:0]          status_d;
    logic                accept, bit_end, last_bit, lock_ok, tmo_done;

    pll_cfg_sync2 u_lock_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign accept   = (state_q == ST_IDLE) && req_valid;
    assign bit_end  = (phase_q == PH_W'(2 * SCLK_DIV - 1));
    assign last_bit = (bit_q == '0);
    assign lock_ok  = lock_s && lock_prev_q;
    assign tmo_done = (tmo_q == TMO_W'(LOCK_TIMEOUT - 1));

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; lock wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (accept) state_d = ST_HOLD;
            ST_HOLD:      if (hold_q == HOLD_W'(RST_HOLD - 1)) state_d = ST_SHIFT;
            ST_SHIFT:     if (bit_end && last_bit) state_d = ST_RELEASE;
            ST_RELEASE:   state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (lock_ok || tmo_done) state_d = ST_RESP;
            ST_RESP:      if (rsp_ready) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values of counters and registered pins, so the pins line up with the state.
    always_comb begin
        hold_d   = hold_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        tmo_d    = tmo_q;
        resetb_d = pll_resetb;
        status_d = rsp_status;
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                if (accept) resetb_d = 1'b0;
            end
            ST_HOLD: begin
                hold_d  = hold_q + HOLD_W'(1);
                phase_d = '0;
                bit_d   = BIT_W'(CFG_BITS - 1);
            end
            ST_SHIFT: begin
                if (bit_end) begin
                    phase_d = '0;
                    bit_d   = bit_q - BIT_W'(1);
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
                if (state_d == ST_RELEASE) begin
                    resetb_d = 1'b1;
                    tmo_d    = '0;
                end
            end
            ST_RELEASE, ST_WAIT_LOCK: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (state_d == ST_RESP) status_d = lock_ok ? STATUS_LOCKED : STATUS_TIMEOUT;
            end
            default: ;
        endcase
        sclk_d = (state_d == ST_SHIFT) && (phase_d >= PH_W'(SCLK_DIV));
        sdi_d  = (state_d == ST_SHIFT) && data_q[bit_d];
    end

    // Datapath and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q      <= '0;
            phase_q     <= '0;
            bit_q       <= '0;
            tmo_q       <= '0;
            data_q      <= '0;
            lock_prev_q <= 1'b0;
            pll_sclk    <= 1'b0;
            pll_sdi     <= 1'b0;
            pll_resetb  <= 1'b0;
            rsp_status  <= STATUS_LOCKED;
            rsp_valid   <= 1'b0;
            busy        <= 1'b0;
            req_ready   <= 1'b1;
        end else begin
            hold_q      <= hold_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            tmo_q       <= tmo_d;
            lock_prev_q <= lock_s;
            if (accept) data_q <= req_data;
            pll_sclk    <= sclk_d;
            pll_sdi     <= sdi_d;
            pll_resetb  <= resetb_d;
            rsp_status  <= status_d;
            rsp_valid   <= (state_d == ST_RESP);
            busy        <= (state_d != ST_IDLE);
            req_ready   <= (state_d == ST_IDLE);
        end
    end

`ifdef PLL_CFG_READBACK_EN
    logic [CFG_BITS-1:0] rdata_q;

    // Shift SDO in on every SCLK rising edge; the first bit received ends up in the MSB.
    always_ff @(posedge CLK) begin
        if (RST)                     rdata_q <= '0;
        else if (accept)             rdata_q <= '0;
        else if (sclk_d && !pll_sclk) rdata_q <= {rdata_q[CFG_BITS-2:0], pll_sdo};
    end

    assign rsp_rdata = rdata_q;
`else
    logic unused_sdo;
    assign unused_sdo = pll_sdo;
    assign rsp_rdata  = '0;
`endif

endmodule
